// File: rtl/dm_store_sequencer.sv
// dm_store_sequencer: issues CPU stores (sw/sh/sb) to a word-wide, synchronous-read
// data memory. Full words are written directly; sub-word stores read the old word,
// merge the new lane and write it back.
// Optional build macro: DM_STORE_MISALIGN_EXC_EN (misaligned sh/sw raise err and are dropped).
module dm_store_sequencer #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_type,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              err
);

  localparam logic [1:0] T_SH = 2'b01;
  localparam logic [1:0] T_SB = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        type_q;
  logic [31:0]       wdata_q;
  logic              accept;
  logic              subword;
  logic              misal;

  // Replace the low or high halfword of a memory word.
  function automatic logic [31:0] merge_half(input logic [31:0] old,
                                             input logic [15:0] h,
                                             input logic        hi);
    return hi ? {h, old[15:0]} : {old[31:16], h};
  endfunction

  // Replace one byte lane of a memory word.
  function automatic logic [31:0] merge_byte(input logic [31:0] old,
                                             input logic [7:0]  b,
                                             input logic [1:0]  lane);
    logic [31:0] m;
    m = old;
    case (lane)
      2'd0:    m[7:0]   = b;
      2'd1:    m[15:8]  = b;
      2'd2:    m[23:16] = b;
      default: m[31:24] = b;
    endcase
    return m;
  endfunction

  assign accept  = (state == IDLE) && req_valid;
  assign subword = (req_type == T_SH) || (req_type == T_SB);

`ifdef DM_STORE_MISALIGN_EXC_EN
  logic err_q;

  // sh needs an even address, sw (and reserved) a word-aligned one; sb is always legal.
  assign misal = ((req_type == T_SH) && req_addr[0]) ||
                 (!subword && (req_addr[1:0] != 2'b00));

  // err pulses for one cycle after a misaligned request is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= accept && misal;
  end

  assign err = err_q;
`else
  assign misal = 1'b0;
  assign err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture the request only at acceptance so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      type_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      type_q  <= req_type;
      wdata_q <= req_wdata;
    end
  end

  // Saturating count of cycles the CPU spends waiting on a busy sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (req_valid && !req_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  // Next-state and output decode; the merge uses mem_rdata still holding the RD result.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    done      = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misal)        state_nxt = IDLE;
          else if (subword) state_nxt = RD;
          else              state_nxt = WR;
        end
      end
      RD: begin
        mem_re    = 1'b1;
        mem_addr  = addr_q[ADDR_W+1:2];
        state_nxt = WR;
      end
      WR: begin
        mem_we    = 1'b1;
        done      = 1'b1;
        mem_addr  = addr_q[ADDR_W+1:2];
        case (type_q)
          T_SH:    mem_wdata = merge_half(mem_rdata, wdata_q[15:0], addr_q[1]);
          T_SB:    mem_wdata = merge_byte(mem_rdata, wdata_q[7:0], addr_q[1:0]);
          default: mem_wdata = wdata_q;
        endcase
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/dm_store_sequencer.md
Name: dm_store_sequencer

Overview:
Sequences CPU stores into the word-wide data memory.
- Full-word stores (sw) are written in one write cycle.
- Sub-word stores (sb, sh) use a read-modify-write: read the old word, merge the new byte or halfword into its lane, write back.
- Sits between the MEM-stage store request and the synchronous-read DM; the CPU holds the request while `req_ready` is low.

Parameters:
ADDR_W, 12, word-address width of DM (byte address is ADDR_W+2 bits)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  store request present
req_ready  output  1  sequencer can accept a request
req_type  input  2  00=sw, 01=sh, 10=sb, 11=reserved (treated as sw)
req_addr  input  ADDR_W+2  byte address
req_wdata  input  32  store data from rt (sh uses [15:0], sb uses [7:0])
done  output  1  one-cycle pulse when the DM write for a request is issued
mem_addr  output  ADDR_W  DM word address
mem_re  output  1  DM read enable; data appears on mem_rdata the next cycle
mem_rdata  input  32  DM read data
mem_we  output  1  DM write enable
mem_wdata  output  32  DM write data
stall_cnt  output  CNT_W  cycles with req_valid=1 and req_ready=0, saturating
err  output  1  misalignment flag (only with the optional feature; otherwise tied 0)

Behaviour:
- States: IDLE, RD, WR.
- Reset (async, reset=0): state=IDLE; latched addr/type/data=0; stall_cnt=0. All outputs 0 except req_ready=1.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, type and wdata.
  - sw or reserved type -> WR; sh or sb -> RD.
- RD:
  - req_ready=0, mem_re=1, mem_addr=latched addr[ADDR_W+1:2].
  - Next state is always WR.
- WR:
  - req_ready=0, mem_we=1, done=1, mem_addr=latched word address.
  - Next state IDLE. A new request can be accepted the cycle after WR.
- WR data:
  - sw: latched wdata.
  - sh: mem_rdata with lane 1:0 replaced by wdata[15:0] when addr[1]=0, or lane 3:2 replaced when addr[1]=1; addr[0] is ignored.
  - sb: mem_rdata with byte lane addr[1:0] replaced by wdata[7:0].
  - Merge is combinational in WR from mem_rdata, which holds the RD-cycle read result.
- Latency from acceptance to done: sw = 1 cycle; sh/sb = 2 cycles.
- Throughput: sw one per 2 cycles, sh/sb one per 3 cycles.
- mem_re and mem_we are never both 1.
- Request inputs are sampled only in the IDLE acceptance cycle; later changes do not affect an in-flight request.
- stall_cnt:
  - Increments each cycle with req_valid=1 and req_ready=0.
  - Holds at all-ones (saturates, no wrap).
  - Cleared only by reset.
- Reset asserted mid-operation (RD or WR): return to IDLE immediately. No write is issued after reset asserts; the partial request is discarded without done.
- Outputs other than mem_wdata are 0 whenever the state does not drive them. mem_wdata is 0 outside WR.

Optional Feature:
DM_STORE_MISALIGN_EXC_EN
- Defined: in IDLE, a request is misaligned if it is sh with addr[0]=1, or sw with addr[1:0]!=0.
  - A misaligned request is accepted: req_ready=1 in that cycle.
  - Next cycle: err pulses 1 for one cycle, state stays IDLE, and no mem_re, mem_we or done is issued.
  - sb is never misaligned.
- Not defined: err is tied 0; alignment bits are ignored as described in Behaviour.

Test Plan:
- sw, addr=0x010, wdata=0xDEADBEEF -> next cycle mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF, done=1; req_ready back to 1 the cycle after.
- sb, addr=0x006, wdata=0x000000AB, DM word 1 = 0x11223344 -> RD cycle mem_re=1, mem_addr=1; WR cycle mem_wdata=0x11AB3344, done=1.
- sh, addr=0x00A, wdata=0x0000CAFE, DM word 2 = 0x55667788 -> WR mem_wdata=0xCAFE7788; sh addr=0x008 with the same word -> 0x5566CAFE.
- Back-to-back requests with req_valid held high through sb then sw -> sw accepted exactly 3 cycles after the sb acceptance; stall_cnt increments by 2; request inputs changed during RD do not alter the sb merge.
- Reset pulled low during the RD state of an sb -> state IDLE, mem_we never asserted, done not pulsed, stall_cnt=0, req_ready=1.
- With DM_STORE_MISALIGN_EXC_EN defined: sw addr=0x013 -> err=1 one cycle, no mem_we and no done; without the macro, the same request writes mem_addr=4.
